// File: rtl/pkt_rx_deframer.sv
// Store-and-forward deframer for LEN / payload / CSUM byte frames.
// Good payloads are replayed with sop/eop framing; bad frames are dropped.
module pkt_rx_deframer #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [7:0]       out_len,
  output logic             pkt_ok,
  output logic             err_csum,
  output logic             err_len,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       dbg_state
);
  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, SEND} state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d, sum_q, sum_d, idx_q, idx_d, rd_q, rd_d;
  logic             out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             pkt_ok_q, pkt_ok_d, err_csum_q, err_csum_d, err_len_q, err_len_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [7:0]       mem_q [MAX_LEN];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr, mem_raddr;
  logic [7:0]       mem_rdata, rd_nxt, csum_chk, len_m1;
  logic             in_xfer, out_xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A byte moves on either port only when valid and ready are both high at
  // posedge; in_ready depends on state alone, never on in_valid.
  assign in_ready  = (state_q != SEND);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign rd_nxt    = rd_q + 8'd1;
  assign len_m1    = len_q - 8'd1;
  assign csum_chk  = sum_q + in_data;
  assign mem_rdata = mem_q[mem_raddr];

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    pkt_ok_d    = 1'b0;
    err_csum_d  = 1'b0;
    err_len_d   = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = idx_q[AW-1:0];
    mem_raddr   = '0;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
            err_len_d  = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
          end else begin
            len_d   = in_data;
            sum_d   = in_data;
            idx_d   = 8'd0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (in_xfer) begin
          mem_we = 1'b1;
          sum_d  = sum_q + in_data;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_m1) state_d = CSUM;
        end
      end
      CSUM: begin
        if (in_xfer) begin
          if (csum_chk == 8'd0) begin
            // Preload the first payload byte so out_valid rises one cycle later.
            pkt_ok_d    = 1'b1;
            pkt_cnt_d   = sat_inc(pkt_cnt_q);
            rd_d        = 8'd0;
            out_valid_d = 1'b1;
            out_data_d  = mem_rdata;
            out_sop_d   = 1'b1;
            out_eop_d   = (len_q == 8'd1);
            state_d     = SEND;
          end else begin
            err_csum_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
            state_d    = IDLE;
          end
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (rd_q == len_m1) begin
            out_valid_d = 1'b0;
            out_data_d  = 8'd0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            state_d     = IDLE;
          end else begin
            mem_raddr  = rd_nxt[AW-1:0];
            rd_d       = rd_nxt;
            out_data_d = mem_rdata;
            out_sop_d  = 1'b0;
            out_eop_d  = (rd_nxt == len_m1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      rd_q        <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pkt_ok_q    <= 1'b0;
      err_csum_q  <= 1'b0;
      err_len_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      pkt_ok_q    <= pkt_ok_d;
      err_csum_q  <= err_csum_d;
      err_len_q   <= err_len_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Frame buffer needs no reset; only bytes of the current frame are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= in_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_len   = len_q;
  assign pkt_ok    = pkt_ok_q;
  assign err_csum  = err_csum_q;
  assign err_len   = err_len_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pkt_rx_deframer.sv
// Bench for pkt_rx_deframer: frame table + random frames feed a byte driver,
// a negedge monitor pops expected output beats from a scoreboard queue.
module tb_pkt_rx_deframer;
  localparam int MAX_LEN = 64;
  localparam int CNT_W   = 16;
  localparam int SBW     = 18;

  logic             clk, rst_n;
  logic             in_valid, in_ready;
  logic [7:0]       in_data;
  logic             out_valid, out_ready;
  logic [7:0]       out_data, out_len;
  logic             out_sop, out_eop;
  logic             pkt_ok, err_csum, err_len;
  logic [CNT_W-1:0] pkt_cnt, drop_cnt;
  logic [1:0]       dbg_state;

  pkt_rx_deframer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_len(out_len),
    .pkt_ok(pkt_ok), .err_csum(err_csum), .err_len(err_len),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;
  int exp_ok = 0, exp_csum = 0, exp_len = 0;
  int got_ok = 0, got_csum = 0, got_len = 0;
  int rdy_mode = 0;
  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] mon_e;
  logic           prev_stall = 1'b0;
  logic [9:0]     prev_out = '0;

  typedef struct {
    logic [7:0] len;
    logic [7:0] base;
    logic [7:0] step;
    bit         use_csum;   // 1: csum is the literal CSUM byte; 0: csum is an offset to the correct one
    logic [7:0] csum;
    int         rdy;
    bit         gaps;
    bit         want_ok;
    bit         want_ecs;
    bit         want_elen;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // out_ready pattern generator
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      got_ok = 0; got_csum = 0; got_len = 0;
      prev_stall = 1'b0;
    end else begin
      if (pkt_ok || err_csum || err_len) begin
        check("pulse_onehot", 32'(pkt_ok) + 32'(err_csum) + 32'(err_len), 32'd1);
        if (pkt_ok)   got_ok++;
        if (err_csum) got_csum++;
        if (err_len)  got_len++;
      end
      if (out_valid) check("in_ready_in_send", 32'(in_ready), 32'd0);
      if (prev_stall)
        check("stall_hold", 32'({out_valid, out_sop, out_eop, out_data}), 32'({1'b1, prev_out}));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_sop, out_eop, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: actual data 0x%0h, required no output", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_beat{len,sop,eop,data}", 32'({out_len, out_sop, out_eop, out_data}), 32'(mon_e));
        end
      end
    end
  end

  // driver tasks
  task automatic drive_byte(input logic [7:0] b);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL in_ready_timeout: actual 0 required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int guard = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: actual %0d beats pending required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ok_pulses"},   32'(got_ok),   32'(exp_ok));
    check({tag, "_csum_pulses"}, 32'(got_csum), 32'(exp_csum));
    check({tag, "_len_pulses"},  32'(got_len),  32'(exp_len));
    check({tag, "_pkt_cnt"},     32'(pkt_cnt),  32'(exp_ok));
    check({tag, "_drop_cnt"},    32'(drop_cnt), 32'(exp_csum + exp_len));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_fields"}, 32'({out_sop, out_eop, out_data, out_len}), 32'd0);
    check({tag, "_pulses"}, 32'({pkt_ok, err_csum, err_len}), 32'd0);
    check({tag, "_counters"}, 32'({pkt_cnt, drop_cnt}), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] sum, b, c;
    rdy_mode = v.rdy;
    drive_byte(v.len);
    if (v.want_elen) begin
      exp_len++;
    end else begin
      sum = v.len;
      for (int i = 0; i < int'(v.len); i++) begin
        b = v.base + 8'(i) * v.step;
        sum += b;
        if (v.want_ok) exp_q.push_back({v.len, (i == 0), (i == int'(v.len) - 1), b});
        if (v.gaps) idle($urandom_range(0, 2));
        drive_byte(b);
      end
      c = v.use_csum ? v.csum : (8'd0 - sum + v.csum);
      drive_byte(c);
      if (v.want_ok)  exp_ok++;
      if (v.want_ecs) exp_csum++;
    end
    wait_drain();
    check_counts("frame");
  endtask

  initial begin
    vec_t r;
    bit   corrupt;

    //            len    base   step   lit   csum   rdy gaps ok   ecs  elen
    vecs[0]  = '{8'h03, 8'h01, 8'h01, 1'b1, 8'hF7, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h01, 8'h01, 1'b1, 8'hF6, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{8'h03, 8'h01, 8'h01, 1'b1, 8'hF7, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'h02, 8'hAA, 8'hAB, 1'b1, 8'hFF, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h40, 8'h00, 8'h01, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h41, 8'h00, 8'h00, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'h01, 8'h42, 8'h00, 1'b0, 8'h00, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h05, 8'h0A, 8'h01, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{8'h3F, 8'h80, 8'h03, 1'b0, 8'h00, 2, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[k]) run_frame(vecs[k]);

    for (int n = 0; n < 20; n++) begin
      corrupt     = ($urandom_range(0, 3) == 0);
      r.len       = 8'($urandom_range(1, MAX_LEN));
      r.base      = 8'($urandom_range(0, 255));
      r.step      = 8'($urandom_range(0, 255));
      r.use_csum  = 1'b0;
      r.csum      = corrupt ? 8'($urandom_range(1, 255)) : 8'h00;
      r.rdy       = 2;
      r.gaps      = 1'b1;
      r.want_ok   = !corrupt;
      r.want_ecs  = corrupt;
      r.want_elen = 1'b0;
      run_frame(r);
    end

    // reset mid-payload of a LEN=10 frame
    rdy_mode = 0;
    drive_byte(8'd10);
    for (int i = 0; i < 4; i++) drive_byte(8'(i + 1));
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midframe_reset");
    rst_n = 1'b1;
    exp_ok = 0; exp_csum = 0; exp_len = 0;
    exp_q.delete();
    run_frame(vecs[0]);

    // back-to-back single-byte frames, in_valid held high
    rdy_mode = 0;
    for (int n = 0; n < 300; n++) begin
      exp_q.push_back({8'h01, 1'b1, 1'b1, 8'h7E});
      drive_byte(8'h01);
      drive_byte(8'h7E);
      drive_byte(8'h81);
      exp_ok++;
    end
    wait_drain();
    check_counts("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_chk++; n_fail++;
    $display("FAIL global_timeout: actual time limit reached, required test end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
